// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: tick-paced 8N1 UART transmit sequencer with start/busy/done handshake.
// Ports: clk, rst (async active-low), i_tick, i_tx_start, i_data -> o_tx, o_busy, o_tx_done.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int SMAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
    localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(STOP_TICKS - 1);
    localparam logic [2:0]    N_LAST      = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state, state_d;
    logic [SW-1:0]        s, s_d;
    logic [2:0]           n, n_d;
    logic [DATA_BITS-1:0] b, b_d;
    logic                 tx_d;
    logic                 done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_d;
            s         <= s_d;
            n         <= n_d;
            b         <= b_d;
            o_tx      <= tx_d;
            o_tx_done <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        s_d     = s;
        n_d     = n;
        b_d     = b;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (i_tx_start) begin
                    b_d     = i_data;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s == S_BIT_LAST) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = b >> 1;
                        if (n == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n + 3'd1;
                        end
                    end else begin
                        s_d = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s == S_STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so it changes
    // together with the state, one cycle after the deciding edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign o_busy = (state != IDLE);

endmodule
